aes_decipher_iter: RTL and testbench

//  Iterative AES-128/256 decryption datapath plus control. Runs the full inverse cipher:
//   - initial AddRoundKey;
//   - Nr-1 main rounds;
//   - one final round.

---
 rtl/aes_decipher_iter.sv | 140 ++++++++++++++
 tb/tb_aes_decipher_iter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_iter.sv
// aes_decipher_iter: iterative AES-128/256 inverse cipher with SWORDS time-shared inverse S-box words.
// Optional macro AES_DEC_ZEROIZE_EN forces new_block to zero while busy.
module aes_decipher_iter #(
    parameter int SWORDS = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round_key_addr,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);
    typedef enum logic [1:0] {IDLE, INIT, SUB, ROUND} state_t;
    localparam logic [1:0] LAST_GRP = 2'(4 / SWORDS - 1);

    state_t       r_fsm, w_fsm_nxt;
    logic [127:0] r_state, w_state_nxt, w_t;
    logic [3:0]   r_round_ctr, w_round_nxt;
    logic [1:0]   r_sword_ctr, w_sword_nxt;
    logic         r_keylen, w_keylen_nxt;
    logic [31:0]  w_sbox_out [SWORDS];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // inverse affine map, then GF(2^8) inverse as a^254 by an addition chain
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a, a2, a3, a6, a12, a240;
        a    = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a6   = gmul(a3, a3);
        a12  = gmul(a6, a6);
        a240 = gmul(a12, a3);
        for (int i = 0; i < 4; i++) a240 = gmul(a240, a240);
        return gmul(gmul(a240, a12), a2);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    // row r rotates right by r columns
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    for (genvar g = 0; g < SWORDS; g++) begin : g_sword
        logic [31:0] w_in;
        assign w_in = r_state[127-32*((int'(r_sword_ctr)*SWORDS+g)%4) -: 32];
        assign w_sbox_out[g] = {inv_sbox(w_in[31:24]), inv_sbox(w_in[23:16]),
                                inv_sbox(w_in[15:8]), inv_sbox(w_in[7:0])};
    end

    assign w_t = inv_shift_rows(r_state) ^ round_key;

    always_comb begin
        w_fsm_nxt    = r_fsm;
        w_state_nxt  = r_state;
        w_round_nxt  = r_round_ctr;
        w_sword_nxt  = r_sword_ctr;
        w_keylen_nxt = r_keylen;
        case (r_fsm)
            IDLE: if (next) begin
                w_state_nxt  = block;
                w_keylen_nxt = keylen;
                w_fsm_nxt    = INIT;
            end
            INIT: begin
                w_state_nxt = r_state ^ round_key;
                w_round_nxt = r_keylen ? 4'd13 : 4'd9;
                w_sword_nxt = 2'd0;
                w_fsm_nxt   = SUB;
            end
            SUB: begin
                for (int j = 0; j < SWORDS; j++)
                    w_state_nxt[127-32*((int'(r_sword_ctr)*SWORDS+j)%4) -: 32] = w_sbox_out[j];
                w_sword_nxt = (r_sword_ctr == LAST_GRP) ? 2'd0 : r_sword_ctr + 2'd1;
                w_fsm_nxt   = (r_sword_ctr == LAST_GRP) ? ROUND : SUB;
            end
            ROUND: begin
                w_state_nxt = (r_round_ctr != 4'd0) ? inv_mix_cols(w_t) : w_t;
                w_round_nxt = (r_round_ctr != 4'd0) ? r_round_ctr - 4'd1 : r_round_ctr;
                w_fsm_nxt   = (r_round_ctr != 4'd0) ? SUB : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_round_ctr <= '0;
            r_sword_ctr <= '0;
            r_keylen    <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_state     <= w_state_nxt;
            r_round_ctr <= w_round_nxt;
            r_sword_ctr <= w_sword_nxt;
            r_keylen    <= w_keylen_nxt;
        end
    end

    assign ready          = (r_fsm == IDLE);
    assign round_key_addr = (r_fsm == INIT) ? (r_keylen ? 4'd14 : 4'd10) : r_round_ctr;
`ifdef AES_DEC_ZEROIZE_EN
    assign new_block = ready ? r_state : '0;
`else
    assign new_block = r_state;
`endif
endmodule

// File: tb/tb_aes_decipher_iter.sv
// tb_aes_decipher_iter: runs SWORDS=4 and SWORDS=1 instances side by side against FIPS-197 vectors,
// with a key-memory model filled by a reference key expansion and a queue of expected results.
module tb_aes_decipher_iter;
    localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;

    typedef struct packed { logic [127:0] pt; logic kl; } exp_t;

    logic clk = 1'b0, reset_n = 1'b0, next = 1'b0, keylen = 1'b0;
    logic [127:0] block = '0;
    logic [1:0] rdy;
    logic [1:0][127:0] nb;
    logic [1:0][3:0] addr;
    logic [127:0] rk_mem [16];
    exp_t exp_q [$];
    int rd [2] = '{0, 0};
    int cnt [2] = '{0, 0};
    bit busy [2] = '{0, 0};
    logic [127:0] hold [2];
    int n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    aes_decipher_iter #(.SWORDS(4)) u_dut_w4 (
        .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen),
        .round_key_addr(addr[0]), .round_key(rk_mem[addr[0]]), .block(block),
        .new_block(nb[0]), .ready(rdy[0]));

    aes_decipher_iter #(.SWORDS(1)) u_dut_w1 (
        .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen),
        .round_key_addr(addr[1]), .round_key(rk_mem[addr[1]]), .block(block),
        .new_block(nb[1]), .ready(rdy[1]));

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 7; i >= 0; i--) p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00) ^ (b[i] ? a : 8'h00);
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h01;
        for (int i = 0; i < 254; i++) y = gm(y, x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic load_key(input logic kl, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) w[i] = key[255-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gm(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) t = sub_word(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // called on a falling edge; the accept happens at the following rising edge
    task automatic start(input logic [127:0] ct, input logic kl, input logic [127:0] pt, input bit hold_next);
        block = ct;
        keylen = kl;
        next = 1'b1;
        exp_q.push_back({pt, kl});
        @(negedge clk);
        if (!hold_next) begin
            next = 1'b0;
            block = {$urandom, $urandom, $urandom, $urandom};
            keylen = ~kl;
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300 && rdy != 2'b11; i++) @(negedge clk);
        if (i == 300) check("idle_timeout", 128'(rdy), 128'(2'b11));
    endtask

    // scoreboard: per instance, follow each busy period and compare at the rising edge of ready
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            int nr, w;
            e  = (rd[d] < exp_q.size()) ? exp_q[rd[d]] : '0;
            nr = e.kl ? 14 : 10;
            w  = (d == 0) ? 1 : 4;
            if (!reset_n) begin
                if (busy[d]) rd[d]++;
                busy[d] = 1'b0;
                hold[d] = '0;
            end else if (!rdy[d]) begin
                if (!busy[d]) begin
                    busy[d] = 1'b1;
                    cnt[d] = 0;
                    check($sformatf("d%0d_start_expected", d), 128'(rd[d] < exp_q.size()), 128'(1));
                end
                check($sformatf("d%0d_addr_c%0d", d, cnt[d]), 128'(addr[d]),
                      128'((cnt[d] == 0) ? nr : nr - 1 - (cnt[d] - 1) / (w + 1)));
`ifdef AES_DEC_ZEROIZE_EN
                check($sformatf("d%0d_busy_zero", d), nb[d], '0);
`endif
                cnt[d]++;
            end else begin
                if (busy[d]) begin
                    busy[d] = 1'b0;
                    check($sformatf("d%0d_plaintext", d), nb[d], e.pt);
                    check($sformatf("d%0d_latency", d), 128'(cnt[d]), 128'(1 + nr * (w + 1)));
                    hold[d] = e.pt;
                    if (rd[d] < exp_q.size()) rd[d]++;
                end
                check($sformatf("d%0d_idle_hold", d), nb[d], hold[d]);
                check($sformatf("d%0d_idle_addr", d), 128'(addr[d]), 128'(0));
            end
        end
    end

    initial begin
        int i;
        for (int k = 0; k < 16; k++) rk_mem[k] = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_reset_ready", d), 128'(rdy[d]), 128'(1));
            check($sformatf("d%0d_reset_block", d), nb[d], '0);
            check($sformatf("d%0d_reset_addr", d), 128'(addr[d]), 128'(0));
        end
        load_key(1'b0, C1_KEY);
        start(C1_CT, 1'b0, PT, 1'b0);
        wait_idle();
        load_key(1'b1, C3_KEY);
        start(C3_CT, 1'b1, PT, 1'b0);
        wait_idle();
        // next held high and inputs scrambled for the whole run
        load_key(1'b0, C1_KEY);
        start(C1_CT, 1'b0, PT, 1'b1);
        block = '0;
        keylen = 1'b1;
        for (i = 0; i < 100 && !rdy[0]; i++) @(negedge clk);
        if (i == 100) check("hold_timeout", 128'(rdy[0]), 128'(1));
        next = 1'b0;
        wait_idle();
        // reset eight cycles into an AES-256 run
        load_key(1'b1, C3_KEY);
        start(C3_CT, 1'b1, PT, 1'b0);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_abort_ready", d), 128'(rdy[d]), 128'(1));
            check($sformatf("d%0d_abort_block", d), nb[d], '0);
        end
        reset_n = 1'b1;
        load_key(1'b0, C1_KEY);
        start(C1_CT, 1'b0, PT, 1'b0);
        wait_idle();
        // back-to-back with a keylen change
        start(C1_CT, 1'b0, PT, 1'b0);
        wait_idle();
        load_key(1'b1, C3_KEY);
        start(C3_CT, 1'b1, PT, 1'b0);
        wait_idle();
        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++) check($sformatf("d%0d_drained", d), 128'(rd[d]), 128'(exp_q.size()));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
